cook_controller: RTL

Top-level sequencing FSM for the microwave MS timer chain, which is built from cascaded MOD6/MOD10 down-counters.
- Turns the start/stop keys, the door sensor and the timer's zero flag into load, clear and enable pulses for the timer.
- Drives the magnetron, lamp and beeper.
- Contains the 1 Hz tick prescaler that paces the countdown.

---
 rtl/cook_controller_pkg.sv | 14 +
 rtl/cook_controller_if.sv | 30 +++
 rtl/cook_controller_tick_prescaler.sv | 32 +++
 rtl/cook_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cook_controller_pkg.sv
// Shared types and defaults for the microwave cook controller.
package cook_controller_pkg;

  localparam int unsigned TICK_DIV_DEFAULT  = 100;
  localparam int unsigned BEEP_SECS_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } cook_state_e;

endpackage

// File: rtl/cook_controller_if.sv
// Key/sensor inputs and timer/appliance drives of the cook controller.
interface cook_controller_if;
  import cook_controller_pkg::*;

  logic        start;
  logic        stop;
  logic        door_closed;
  logic        key_load;
  logic        timer_zero;
  logic        timer_load_n;
  logic        timer_clear_n;
  logic        timer_enab;
  logic        magnetron_on;
  logic        lamp_on;
  logic        beep;
  cook_state_e state;

  // Panel / timer side
  modport master (
    output start, stop, door_closed, key_load, timer_zero,
    input  timer_load_n, timer_clear_n, timer_enab, magnetron_on, lamp_on, beep, state
  );

  // Controller side
  modport slave (
    input  start, stop, door_closed, key_load, timer_zero,
    output timer_load_n, timer_clear_n, timer_enab, magnetron_on, lamp_on, beep, state
  );

endinterface

// File: rtl/cook_controller_tick_prescaler.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 while run, pulses tick on the last count.
module cook_controller_tick_prescaler
  import cook_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // restart wins over run so every state entry starts a fresh second
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/cook_controller.sv
// Microwave sequencing FSM: keys, door and timer-zero in; timer strobes and appliance drives out.
module cook_controller
  import cook_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int unsigned BEEP_SECS = BEEP_SECS_DEFAULT
) (
  input logic              clk,
  input logic              clear,
  cook_controller_if.slave bus
);

  localparam int unsigned SEC_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(BEEP_SECS - 1);

  cook_state_e      state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             start_q, stop_q;
  logic             load_n_q, load_n_d;
  logic             clear_n_q, clear_n_d;
  logic             enab_q, enab_d;
  logic             magnetron_q, lamp_q, beep_q;
  logic             start_edge, stop_edge;
  logic             run, restart, tick;

  assign start_edge = bus.start && !start_q;
  assign stop_edge  = bus.stop && !stop_q;

  assign run     = (state_q == ST_COOKING) || (state_q == ST_DONE);
  assign restart = (state_d != state_q);

  cook_controller_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk     (clk),
    .clear   (clear),
    .run     (run),
    .restart (restart),
    .tick    (tick)
  );

  // Next state and strobes; case order encodes stop > door > timer_zero > start > key_load
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    load_n_d  = 1'b1;
    clear_n_d = 1'b1;
    enab_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop_edge) begin
          clear_n_d = 1'b0;
        end else if (start_edge && bus.door_closed && !bus.timer_zero) begin
          state_d = ST_COOKING;
        end else if (bus.key_load) begin
          load_n_d = 1'b0;
        end
      end
      ST_COOKING: begin
        if (stop_edge || !bus.door_closed) begin
          state_d = ST_PAUSED;
        end else if (bus.timer_zero) begin
          state_d = ST_DONE;
        end else if (tick) begin
          enab_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (stop_edge) begin
          state_d   = ST_IDLE;
          clear_n_d = 1'b0;
        end else if (start_edge && bus.door_closed) begin
          state_d = ST_COOKING;
        end
      end
      ST_DONE: begin
        // timer already reads zero, so leaving DONE never clears it
        if (stop_edge || !bus.door_closed) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sec_q == SEC_LAST) begin
            state_d = ST_IDLE;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      sec_d = '0;
    end
  end

  // State, edge history and output registers; reset clears the timer chain alongside
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      start_q     <= 1'b1;
      stop_q      <= 1'b1;
      load_n_q    <= 1'b1;
      clear_n_q   <= 1'b0;
      enab_q      <= 1'b0;
      magnetron_q <= 1'b0;
      lamp_q      <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      start_q     <= bus.start;
      stop_q      <= bus.stop;
      load_n_q    <= load_n_d;
      clear_n_q   <= clear_n_d;
      enab_q      <= enab_d;
      magnetron_q <= (state_d == ST_COOKING);
      lamp_q      <= (state_d == ST_COOKING) || (state_d == ST_PAUSED);
      beep_q      <= (state_d == ST_DONE);
    end
  end

  assign bus.state         = state_q;
  assign bus.timer_load_n  = load_n_q;
  assign bus.timer_clear_n = clear_n_q;
  assign bus.timer_enab    = enab_q;
  assign bus.magnetron_on  = magnetron_q;
  assign bus.lamp_on       = lamp_q;
  assign bus.beep          = beep_q;

endmodule
